tpu_result_collector: RTL and testbench

- Downstream consumer of the 128-element dot-product stage. Accepts one dot-product result (2*bit-1 wide) plus its overflow flag per output neuron.
- Per neuron: applies activation, saturates on overflow and stores the result in a small result buffer.
- Tracks the running argmax over the frame.
- After N_OUT results, raises done with the winning class index (handwritten-digit decision, 0-9).

---
 rtl/tpu_result_collector.sv | 135 +++++++++++++
 tb/tb_tpu_result_collector.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_result_collector.sv
// Result collector: saturates/activates each dot-product result, buffers it and tracks the frame argmax.
// Build option TPU_COLLECT_RELU_EN applies ReLU before storing; BIT_W is the element width ("bit" is a keyword).
module tpu_result_collector #(
   parameter int BIT_W = 16,
   parameter int N_OUT = 10,
   parameter int IDX_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*BIT_W-2:0]   in_data,
   input  logic                 in_overflow,
   input  logic [IDX_W-1:0]     rd_addr,
   output logic [2*BIT_W-2:0]   rd_data,
   output logic                 done,
   output logic [IDX_W-1:0]     class_idx,
   output logic [2*BIT_W-2:0]   class_val,
   output logic                 any_ovf
);
   localparam int W = 2*BIT_W - 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);
   localparam logic [W-1:0]     SAT_VAL  = {1'b0, {(W-1){1'b1}}};

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] class_idx_q, class_idx_d;
   logic [W-1:0]     max_val_q, max_val_d;
   logic [W-1:0]     rd_data_q, rd_data_d;
   logic             any_ovf_q, any_ovf_d;
   logic             done_q, done_d;
   logic [W-1:0]     buf_mem [N_OUT];
   logic [W-1:0]     proc_val;
   logic             is_greater;
   logic             wr_en;

   // Strict "a beats b" in the numeric order of the stored encoding.
   function automatic logic greater(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef TPU_COLLECT_RELU_EN
      return a > b;
`else
      logic a_neg;
      logic b_neg;
      a_neg = a[W-1] && (a[W-2:0] != '0);
      b_neg = b[W-1] && (b[W-2:0] != '0);
      if (a_neg != b_neg) return b_neg;
      if (a_neg) return a[W-2:0] < b[W-2:0];
      return a[W-2:0] > b[W-2:0];
`endif
   endfunction

   always_comb begin
      if (in_overflow) proc_val = SAT_VAL;
`ifdef TPU_COLLECT_RELU_EN
      else if (in_data[W-1]) proc_val = '0;
`endif
      else proc_val = in_data;
   end

   assign is_greater = greater(proc_val, max_val_q);

   always_comb begin
      // NOTE: every _d gets a hold default first, so no path through the case can infer a latch.
      state_d     = state_q;
      count_d     = count_q;
      class_idx_d = class_idx_q;
      max_val_d   = max_val_q;
      any_ovf_d   = any_ovf_q;
      done_d      = done_q;
      wr_en       = 1'b0;
      rd_data_d   = (rd_addr <= LAST_IDX) ? buf_mem[rd_addr] : '0;

      if (start) begin
         state_d     = COLLECT;
         count_d     = '0;
         class_idx_d = '0;
         max_val_d   = '0;
         any_ovf_d   = 1'b0;
         done_d      = 1'b0;
      end else if (state_q == COLLECT && in_valid) begin
         wr_en     = 1'b1;
         any_ovf_d = any_ovf_q | in_overflow;
         if (is_greater || count_q == '0) begin
            max_val_d   = proc_val;
            class_idx_d = count_q;
         end
         if (count_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state is updated only with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         class_idx_q <= '0;
         max_val_q   <= '0;
         any_ovf_q   <= 1'b0;
         done_q      <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         class_idx_q <= class_idx_d;
         max_val_q   <= max_val_d;
         any_ovf_q   <= any_ovf_d;
         done_q      <= done_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // NOTE: the buffer has no reset; every entry is rewritten before a frame can complete.
   always_ff @(posedge clk) begin
      if (wr_en) buf_mem[count_q] <= proc_val;
   end

   assign in_ready  = (state_q == COLLECT);
   assign rd_data   = rd_data_q;
   assign done      = done_q;
   assign class_idx = class_idx_q;
   assign class_val = max_val_q;
   assign any_ovf   = any_ovf_q;

endmodule

// File: tb/tb_tpu_result_collector.sv
// Randomized self-checking bench for tpu_result_collector against a numeric argmax model.
module tb_tpu_result_collector;
   localparam int BIT_W = 16;
   localparam int N_OUT = 10;
   localparam int IDX_W = 4;
   localparam int W     = 2*BIT_W - 1;
   localparam logic [W-1:0] SAT = {1'b0, {(W-1){1'b1}}};

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_overflow = 1'b0;
   logic [W-1:0]     in_data = '0;
   logic [IDX_W-1:0] rd_addr = '0;
   logic             in_ready, done, any_ovf;
   logic [IDX_W-1:0] class_idx;
   logic [W-1:0]     rd_data, class_val;

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] fr_data [N_OUT];
   logic         fr_ovf  [N_OUT];
   logic [W-1:0] ref_buf [N_OUT];
   logic         ref_ovf;
   logic [W-1:0] pool [6] = '{31'h0, 31'h40000000, 31'h1000, 31'h40001000, 31'h3FFFFFFF, 31'h7FFFFFFF};

   always #5 clk = ~clk;

   tpu_result_collector #(.BIT_W(BIT_W), .N_OUT(N_OUT), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_overflow(in_overflow), .rd_addr(rd_addr), .rd_data(rd_data),
      .done(done), .class_idx(class_idx), .class_val(class_val), .any_ovf(any_ovf)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] process(input logic [W-1:0] d, input logic o);
      if (o) return SAT;
`ifdef TPU_COLLECT_RELU_EN
      if (d[W-1]) return '0;
`endif
      return d;
   endfunction

   // Sign-magnitude word as a plain integer; +0 and -0 both map to 0.
   function automatic longint value_of(input logic [W-1:0] v);
      longint m;
      m = longint'(v[W-2:0]);
      return v[W-1] ? -m : m;
   endfunction

   task automatic start_frame(input bit with_valid);
      start       = 1'b1;
      in_valid    = with_valid;
      in_data     = SAT;
      in_overflow = with_valid;
      tick();
      start       = 1'b0;
      in_valid    = 1'b0;
      in_overflow = 1'b0;
      ref_ovf     = 1'b0;
      check("clr_done", done, 0);
      check("clr_idx", class_idx, 0);
      check("clr_val", class_val, 0);
      check("clr_ovf", any_ovf, 0);
      check("clr_rdy", in_ready, 1);
   endtask

   task automatic feed(input int first, input int last, input int gap, input bit rand_gap);
      for (int i = first; i <= last; i++) begin
         int g;
         g = rand_gap ? int'($urandom_range(0, gap)) : gap;
         repeat (g) tick();
         check("rdy", in_ready, 1);
         in_valid    = 1'b1;
         in_data     = fr_data[i];
         in_overflow = fr_ovf[i];
         tick();
         in_valid    = 1'b0;
         in_overflow = 1'b0;
         ref_buf[i]  = process(fr_data[i], fr_ovf[i]);
         ref_ovf     = ref_ovf | fr_ovf[i];
         if (i < N_OUT-1) check("early_done", done, 0);
      end
   endtask

   task automatic check_frame;
      int best;
      best = 0;
      for (int i = 1; i < N_OUT; i++)
         if (value_of(ref_buf[i]) > value_of(ref_buf[best])) best = i;
      check("done", done, 1);
      check("done_rdy", in_ready, 0);
      check("class_idx", class_idx, 64'(best));
      check("class_val", class_val, ref_buf[best]);
      check("any_ovf", any_ovf, ref_ovf);
      for (int a = 0; a < 2**IDX_W; a++) begin
         rd_addr = IDX_W'(a);
         tick();
         check("rd_data", rd_data, (a < N_OUT) ? ref_buf[a] : '0);
      end
   endtask

   initial begin
      repeat (3) tick();
      check("rst_rdy", in_ready, 0);
      check("rst_done", done, 0);
      check("rst_idx", class_idx, 0);
      check("rst_val", class_val, 0);
      check("rst_ovf", any_ovf, 0);
      check("rst_rd", rd_data, 0);
      rst = 1'b0;
      tick();
      check("idle_rdy", in_ready, 0);

      // Ascending ramp: last entry wins.
      for (int i = 0; i < N_OUT; i++) begin
         fr_data[i] = W'(32'h1000 + i*32'h100);
         fr_ovf[i]  = 1'b0;
      end
      start_frame(0);
      feed(0, N_OUT-1, 0, 0);
      check_frame();
      check("ramp_idx", class_idx, 9);
      check("ramp_val", class_val, 31'h1900);
      rd_addr = 4'd3;
      tick();
      check("ramp_rd3", rd_data, 31'h1300);

      // Tie between index 4 and 7 keeps 4.
      for (int i = 0; i < N_OUT; i++) fr_data[i] = 31'h2000;
      fr_data[4] = 31'h3000;
      fr_data[7] = 31'h3000;
      start_frame(0);
      feed(0, N_OUT-1, 0, 0);
      check_frame();
      check("tie_idx", class_idx, 4);

      // Overflow on index 2 saturates regardless of in_data.
      for (int i = 0; i < N_OUT; i++) fr_data[i] = 31'h4000;
      fr_data[2] = 31'h1;
      fr_ovf[2]  = 1'b1;
      start_frame(0);
      feed(0, N_OUT-1, 0, 0);
      check_frame();
      check("ovf_idx", class_idx, 2);
      check("ovf_val", class_val, SAT);
      fr_ovf[2] = 1'b0;

      // All-negative frame.
      for (int i = 0; i < N_OUT; i++) fr_data[i] = W'(32'h40001000 + i*32'h100);
      start_frame(0);
      feed(0, N_OUT-1, 0, 0);
      check_frame();
      check("neg_idx", class_idx, 0);

      // Reset in the middle of a frame, with in_valid held high across it.
      for (int i = 0; i < N_OUT; i++) fr_data[i] = W'(32'h500 + i);
      fr_data[2] = 31'h7000;
      fr_ovf[1]  = 1'b1;
      start_frame(0);
      feed(0, 3, 0, 0);
      in_valid = 1'b1;
      in_data  = SAT;
      rst      = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check("mrst_rdy", in_ready, 0);
      check("mrst_done", done, 0);
      check("mrst_idx", class_idx, 0);
      check("mrst_val", class_val, 0);
      check("mrst_ovf", any_ovf, 0);
      check("mrst_rd", rd_data, 0);
      tick();
      check("mrst_idle_rdy", in_ready, 0);
      check("mrst_idle_done", done, 0);
      in_valid  = 1'b0;
      fr_ovf[1] = 1'b0;
      start_frame(0);
      feed(0, N_OUT-1, 1, 1);
      check_frame();

      // Abort after 6 gapped transfers; the start-cycle transfer must be dropped.
      for (int i = 0; i < N_OUT; i++) fr_data[i] = 31'h6000;
      fr_ovf[3] = 1'b1;
      start_frame(0);
      feed(0, 5, 2, 0);
      fr_ovf[3] = 1'b0;
      start_frame(1);
      for (int i = 0; i < N_OUT; i++) fr_data[i] = W'(32'h800 + ((i*7) % 10) * 32'h10);
      feed(0, N_OUT-1, 2, 0);
      check_frame();

      // In DONE, further in_valid pulses change nothing.
      for (int k = 0; k < 3; k++) begin
         check("done_ign_rdy", in_ready, 0);
         in_valid    = 1'b1;
         in_data     = SAT;
         in_overflow = 1'b1;
         tick();
      end
      in_valid    = 1'b0;
      in_overflow = 1'b0;
      check_frame();

      // Randomized frames mixing random words, tie-prone values, signed zeros and overflow.
      repeat (40) begin
         for (int i = 0; i < N_OUT; i++) begin
            case ($urandom_range(0, 2))
               0:       fr_data[i] = W'($urandom);
               1:       fr_data[i] = pool[$urandom_range(0, 5)];
               default: fr_data[i] = (W'($urandom_range(0, 3)) << 12) | (W'($urandom_range(0, 1)) << (W-1));
            endcase
            fr_ovf[i] = ($urandom_range(0, 7) == 0);
         end
         start_frame(0);
         feed(0, N_OUT-1, 2, 1);
         check_frame();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
